// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage and its consumers.
//   - Default instruction / address widths.
//   - NOP_INSTR: the encoding written into IF/ID for a bubble. Decode uses it
//     for NOP detection.
//   - fetch_state_t: 2-bit fetch FSM encodings.
//   - pc_sel_t: select for the next-pc mux in fetch_pc_unit.
//   - sat_inc32: saturating 32-bit increment, used by the optional
//     performance counters.
package instruction_fetch_stage_pkg;

  localparam int unsigned IF_ADDR_W  = 32;
  localparam int unsigned IF_INSTR_W = 16;

  localparam logic [IF_INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    S_VEC_LO = 2'd0,
    S_VEC_HI = 2'd1,
    S_RUN    = 2'd2,
    S_HOLD   = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2,
    PC_VECTOR   = 2'd3
  } pc_sel_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    sat_inc32 = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_pc_unit.sv
// fetch_pc_unit: program counter register with its next-pc mux and +1 adder.
// Ports:
//   clk, reset   clock / synchronous active-high reset (pc clears to 0)
//   pc_sel       next-pc select: hold, increment, redirect target, vector load
//   redirect_pc  branch/jump target
//   vec_pc       reset vector assembled from the two vector halves
//   pc           current pc
//   pc_plus1     pc + 1, modulo 2^ADDR_W
module fetch_pc_unit
  import instruction_fetch_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = IF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  pc_sel_t           pc_sel,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [ADDR_W-1:0] vec_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Carry out of the adder is dropped so pc wraps from all-ones to zero.
  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign pc       = pc_q;

  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      PC_INC:      pc_d = pc_plus1;
      PC_REDIRECT: pc_d = redirect_pc;
      PC_VECTOR:   pc_d = vec_pc;
      default:     pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: IF stage feeding the IF/ID register.
// After reset it reads a 32-bit reset vector (low half at VEC_ADDR, high half
// at VEC_ADDR+1), then fetches one INSTR_W word per cycle from a combinational
// instruction memory. Handles decode stall, flush, branch redirect and a hold
// while the program loader owns memory.
// Ports:
//   clk, reset            clock / synchronous active-high reset
//   imem_addr, imem_rdata instruction-memory word address and same-cycle data
//   load_busy             loader owns memory; fetch must not advance
//   stall_id              decode cannot accept; hold IF/ID and pc
//   flush                 kill the instruction in IF/ID
//   redirect_valid/pc     load pc from redirect_pc
//   if_id_valid/instr/pc/pc_next   IF/ID register contents
// Optional feature (macro FETCH_PERF_CNT_EN): adds perf_fetched / perf_bubbles
// saturating counters, frozen while stall_id is high.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int unsigned        ADDR_W   = IF_ADDR_W,
  parameter int unsigned        INSTR_W  = IF_INSTR_W,
  parameter logic [ADDR_W-1:0]  VEC_ADDR = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               load_busy,
  input  logic               stall_id,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [ADDR_W-1:0]  if_id_pc_next
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] vec_lo_q, vec_lo_d;
  logic               if_id_valid_q, if_id_valid_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
  logic [ADDR_W-1:0]  if_id_pc_q, if_id_pc_d;
  logic [ADDR_W-1:0]  if_id_pc_next_q, if_id_pc_next_d;

  pc_sel_t            pc_sel;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_plus1;
  logic [ADDR_W-1:0]  vec_pc;
  logic               fetch_wr;   // a real word is written into IF/ID
  logic               bubble_wr;  // a bubble is written into IF/ID

  // The vector is ADDR_W wide, built from the high half on the bus and the
  // latched low half.
  assign vec_pc = ADDR_W'({imem_rdata, vec_lo_q});

  fetch_pc_unit #(
    .ADDR_W(ADDR_W)
  ) u_pc (
    .clk        (clk),
    .reset      (reset),
    .pc_sel     (pc_sel),
    .redirect_pc(redirect_pc),
    .vec_pc     (vec_pc),
    .pc         (pc),
    .pc_plus1   (pc_plus1)
  );

  always_comb begin
    state_d         = state_q;
    vec_lo_d        = vec_lo_q;
    pc_sel          = PC_HOLD;
    imem_addr       = pc;
    if_id_valid_d   = if_id_valid_q;
    if_id_instr_d   = if_id_instr_q;
    if_id_pc_d      = if_id_pc_q;
    if_id_pc_next_d = if_id_pc_next_q;
    fetch_wr        = 1'b0;
    bubble_wr       = 1'b0;

    case (state_q)
      S_VEC_LO: begin
        imem_addr = VEC_ADDR;
        if (!load_busy) begin
          vec_lo_d = imem_rdata;
          state_d  = S_VEC_HI;
        end
      end

      S_VEC_HI: begin
        imem_addr = VEC_ADDR + ADDR_W'(1);
        if (!load_busy) begin
          pc_sel  = PC_VECTOR;
          state_d = S_RUN;
        end else begin
          // Loader may have rewritten the low half; start the vector over.
          state_d = S_VEC_LO;
        end
      end

      S_RUN, S_HOLD: begin
        imem_addr = pc;
        if (redirect_valid) pc_sel = PC_REDIRECT;

        if (state_q == S_HOLD) begin
          if (!load_busy) state_d = S_RUN;
        end else if (load_busy) begin
          state_d = S_HOLD;
        end

        if (stall_id) begin
          // IF/ID held, but a flush still kills what decode is holding
          // (unless a redirect already bubbles it below).
          if (flush || (redirect_valid && state_q == S_RUN && !load_busy)) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_W;
          end
        end else if (state_q == S_HOLD || load_busy || redirect_valid || flush) begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = NOP_W;
          bubble_wr     = 1'b1;
        end else begin
          if_id_valid_d   = 1'b1;
          if_id_instr_d   = imem_rdata;
          if_id_pc_d      = pc;
          if_id_pc_next_d = pc_plus1;
          pc_sel          = PC_INC;
          fetch_wr        = 1'b1;
        end
      end

      default: state_d = S_VEC_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_VEC_LO;
      vec_lo_q        <= '0;
      if_id_valid_q   <= 1'b0;
      if_id_instr_q   <= NOP_W;
      if_id_pc_q      <= '0;
      if_id_pc_next_q <= '0;
    end else begin
      state_q         <= state_d;
      vec_lo_q        <= vec_lo_d;
      if_id_valid_q   <= if_id_valid_d;
      if_id_instr_q   <= if_id_instr_d;
      if_id_pc_q      <= if_id_pc_d;
      if_id_pc_next_q <= if_id_pc_next_d;
    end
  end

  assign if_id_valid   = if_id_valid_q;
  assign if_id_instr   = if_id_instr_q;
  assign if_id_pc      = if_id_pc_q;
  assign if_id_pc_next = if_id_pc_next_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  // fetch_wr / bubble_wr are never set while stall_id is high, which keeps
  // the counters frozen during a stall.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (fetch_wr)  perf_fetched_d = sat_inc32(perf_fetched_q);
    if (bubble_wr) perf_bubbles_d = sat_inc32(perf_bubbles_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`else
  logic unused_wr;
  assign unused_wr = fetch_wr ^ bubble_wr;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        load_busy;
  logic        stall_id;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_next;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  logic [15:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr < 32'd256) ? mem[imem_addr[7:0]] : 16'hBEEF;

  instruction_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .load_busy     (load_busy),
    .stall_id      (stall_id),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_pc_next (if_id_pc_next)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_bubbles  (perf_bubbles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [15:0] ins,
                          input logic [31:0] pcv, input logic [31:0] pcn);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    chk({tag, ".instr"}, {16'd0, if_id_instr}, {16'd0, ins});
    chk({tag, ".pc"}, if_id_pc, pcv);
    chk({tag, ".pc_next"}, if_id_pc_next, pcn);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i) | 16'(i << 8);
    mem[8'h00] = 16'h0020;
    mem[8'h01] = 16'h0000;
    mem[8'h20] = 16'h44BF;
    mem[8'h21] = 16'h1111;
    mem[8'h22] = 16'h2222;

    reset = 1'b1; load_busy = 1'b0; stall_id = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    step();
    chk_ifid("rst", 1'b0, 16'h0000, 32'h0, 32'h0);
    chk("rst.addr", imem_addr, 32'h0);
    reset = 1'b0;

    // Vector fetch
    step(); chk("vec_hi.addr", imem_addr, 32'h1);
    chk("vec_hi.valid", {31'd0, if_id_valid}, 32'd0);
    step(); chk("run.addr", imem_addr, 32'h20);
    chk("run.valid", {31'd0, if_id_valid}, 32'd0);
    step(); chk_ifid("first", 1'b1, 16'h44BF, 32'h20, 32'h21);
    chk("first.addr", imem_addr, 32'h21);

    // Stall two cycles at pc 0x21
    stall_id = 1'b1;
    step(); chk("stall1.instr", {16'd0, if_id_instr}, 32'h44BF);
    chk("stall1.addr", imem_addr, 32'h21);
    step(); chk("stall2.instr", {16'd0, if_id_instr}, 32'h44BF);
    chk("stall2.addr", imem_addr, 32'h21);
    stall_id = 1'b0;
    step(); chk_ifid("seq2", 1'b1, 16'h1111, 32'h21, 32'h22);
    step(); chk_ifid("seq3", 1'b1, 16'h2222, 32'h22, 32'h23);
    chk("seq3.addr", imem_addr, 32'h23);

    // Redirect and stall in the same cycle
    redirect_valid = 1'b1; redirect_pc = 32'h40; stall_id = 1'b1;
    step(); chk("redir.valid", {31'd0, if_id_valid}, 32'd0);
    chk("redir.addr", imem_addr, 32'h40);
    redirect_valid = 1'b0; stall_id = 1'b0;
    step(); chk_ifid("redir.tgt", 1'b1, 16'h4040, 32'h40, 32'h41);
    step(); chk_ifid("redir.seq", 1'b1, 16'h4141, 32'h41, 32'h42);

    // Flush without redirect: bubble, same pc refetched
    flush = 1'b1;
    step(); chk("flush.valid", {31'd0, if_id_valid}, 32'd0);
    chk("flush.instr", {16'd0, if_id_instr}, 32'h0);
    chk("flush.addr", imem_addr, 32'h42);
    flush = 1'b0;
    step(); chk_ifid("flush.refetch", 1'b1, 16'h4242, 32'h42, 32'h43);

    // load_busy for 3 cycles in S_RUN
    load_busy = 1'b1;
    step(); chk("busy1.valid", {31'd0, if_id_valid}, 32'd0);
    step(); chk("busy2.valid", {31'd0, if_id_valid}, 32'd0);
    step(); chk("busy3.valid", {31'd0, if_id_valid}, 32'd0);
    load_busy = 1'b0;
    step(); chk("busy4.valid", {31'd0, if_id_valid}, 32'd0);
    chk("busy4.addr", imem_addr, 32'h43);
    step(); chk_ifid("resume", 1'b1, 16'h4343, 32'h43, 32'h44);

    // Flush while stalled clears valid, pc held
    stall_id = 1'b1; flush = 1'b1;
    step(); chk("sflush.valid", {31'd0, if_id_valid}, 32'd0);
    chk("sflush.addr", imem_addr, 32'h44);
    stall_id = 1'b0; flush = 1'b0;
    step(); chk_ifid("sflush.next", 1'b1, 16'h4444, 32'h44, 32'h45);

    // Wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step(); chk("wrap.addr", imem_addr, 32'hFFFF_FFFF);
    redirect_valid = 1'b0;
    step(); chk_ifid("wrap.top", 1'b1, 16'hBEEF, 32'hFFFF_FFFF, 32'h0);
    chk("wrap.addr0", imem_addr, 32'h0);
    step(); chk_ifid("wrap.zero", 1'b1, 16'h0020, 32'h0, 32'h1);

    // Reset mid-run
    reset = 1'b1;
    step(); chk_ifid("rst2", 1'b0, 16'h0000, 32'h0, 32'h0);
    chk("rst2.addr", imem_addr, 32'h0);
    reset = 1'b0;

    // load_busy in S_VEC_HI restarts the vector fetch
    step(); chk("vb.hi", imem_addr, 32'h1);
    load_busy = 1'b1;
    step(); chk("vb.lo", imem_addr, 32'h0);
    step(); chk("vb.lo_hold", imem_addr, 32'h0);
    load_busy = 1'b0;
    step(); chk("vb.hi2", imem_addr, 32'h1);
    step(); chk("vb.run", imem_addr, 32'h20);
    step(); chk_ifid("vb.first", 1'b1, 16'h44BF, 32'h20, 32'h21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
